// File: rtl/vz16_pkg.sv
// Shared types and widths for the vz16 external memory bus.
package vz16_pkg;

   localparam int VZ16_DATA_W = 16;
   localparam int VZ16_ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_state_t;

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/vz16_wait_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module vz16_wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   localparam logic [W-1:0] L_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - L_ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/vz16_bus_arbiter.sv
// vz16 external bus arbiter: fetch (F) vs load/store (D), single outstanding access.
// Optional macro VZ16_BUS_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES and flags bus_err.
module vz16_bus_arbiter
   import vz16_pkg::*;
#(
   parameter int WAIT_STATES    = 1,
   parameter int FAIR_LIMIT     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   f_req,
   input  logic [VZ16_ADDR_W-1:0] f_addr,
   output logic                   f_gnt,
   output logic                   f_done,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [VZ16_ADDR_W-1:0] d_addr,
   input  logic [VZ16_DATA_W-1:0] d_wdata,
   output logic                   d_gnt,
   output logic                   d_done,
   output logic [VZ16_DATA_W-1:0] rdata,
   output logic [VZ16_ADDR_W-1:0] mem_addr,
   output logic [VZ16_DATA_W-1:0] mem_wdata,
   output logic                   mem_rd,
   output logic                   mem_wr,
   input  logic [VZ16_DATA_W-1:0] mem_rdata,
   input  logic                   mem_ready,
   output logic                   bus_err
);

   localparam logic [3:0] L_WAIT_LOAD  = 4'(WAIT_STATES);
   localparam logic [3:0] L_FAIR_LIMIT = 4'(FAIR_LIMIT);

   bus_state_t             r_state;
   bus_state_t             w_next_state;
   owner_t                 r_owner;
   logic                   r_we;
   logic [VZ16_ADDR_W-1:0] r_mem_addr;
   logic [VZ16_DATA_W-1:0] r_mem_wdata;
   logic [VZ16_DATA_W-1:0] r_rdata;
   logic                   r_mem_rd;
   logic                   r_mem_wr;
   logic                   r_f_done;
   logic                   r_d_done;
   logic                   r_bus_err;
   logic [3:0]             r_fair_cnt;

   logic w_f_gnt;
   logic w_d_gnt;
   logic w_accept;
   logic w_in_access;
   logic w_wait_zero;
   logic w_exit;
   logic w_timeout;
   logic w_leave;

   // Grants are only offered in IDLE; D wins unless F has been passed over FAIR_LIMIT times.
   always_comb begin
      w_f_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (reset && (r_state == IDLE)) begin
         if (f_req && (!d_req || (r_fair_cnt == L_FAIR_LIMIT))) begin
            w_f_gnt = 1'b1;
         end else if (d_req) begin
            w_d_gnt = 1'b1;
         end else begin
            w_f_gnt = 1'b0;
         end
      end else begin
         w_d_gnt = 1'b0;
      end
   end

   assign w_accept    = w_f_gnt | w_d_gnt;
   assign w_in_access = (r_state == ACCESS);
   assign w_exit      = w_in_access & w_wait_zero & mem_ready;
   assign w_leave     = w_exit | w_timeout;

   vz16_wait_counter #(.W(4)) u_wait_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val (L_WAIT_LOAD),
      .i_dec      (w_in_access),
      .o_zero     (w_wait_zero)
   );

`ifdef VZ16_BUS_TIMEOUT_EN
   localparam int                L_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [L_TO_W-1:0] L_TO_LOAD = L_TO_W'(TIMEOUT_CYCLES - 1);

   logic w_to_zero;

   // Reloaded on every grant, so it reaches zero on the last permitted ACCESS cycle.
   vz16_wait_counter #(.W(L_TO_W)) u_timeout_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val (L_TO_LOAD),
      .i_dec      (w_in_access),
      .o_zero     (w_to_zero)
   );

   assign w_timeout = w_in_access & w_to_zero & ~w_exit;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign w_timeout = 1'b0;
`endif

   // Next-state logic for the IDLE -> ACCESS -> RESP -> IDLE cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = ACCESS;
            end else begin
               w_next_state = IDLE;
            end
         end
         ACCESS: begin
            if (w_leave) begin
               w_next_state = RESP;
            end else begin
               w_next_state = ACCESS;
            end
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Fairness counter: counts D grants that bypassed a waiting F, saturating at the limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fair_cnt <= 4'd0;
      end else if (w_f_gnt) begin
         r_fair_cnt <= 4'd0;
      end else if (w_d_gnt && f_req && (r_fair_cnt != L_FAIR_LIMIT)) begin
         r_fair_cnt <= r_fair_cnt + 4'd1;
      end else begin
         r_fair_cnt <= r_fair_cnt;
      end
   end

   // Request latch, bus strobes, read-data capture and completion pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner     <= OWN_F;
         r_we        <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 16'h0000;
         r_rdata     <= 16'h0000;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_f_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_bus_err   <= 1'b0;
      end else begin
         r_f_done  <= 1'b0;
         r_d_done  <= 1'b0;
         r_bus_err <= 1'b0;
         if (w_accept) begin
            r_owner     <= w_d_gnt ? OWN_D : OWN_F;
            r_we        <= w_d_gnt & d_we;
            r_mem_addr  <= w_d_gnt ? d_addr : f_addr;
            r_mem_wdata <= w_d_gnt ? d_wdata : r_mem_wdata;
            r_mem_rd    <= ~(w_d_gnt & d_we);
            r_mem_wr    <= w_d_gnt & d_we;
         end else if (w_leave) begin
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_f_done  <= (r_owner == OWN_F);
            r_d_done  <= (r_owner == OWN_D);
            r_bus_err <= w_timeout;
            if (w_timeout) begin
               r_rdata <= 16'h0000;
            end else if (!r_we) begin
               r_rdata <= mem_rdata;
            end else begin
               r_rdata <= r_rdata;
            end
         end else begin
            r_mem_rd <= r_mem_rd;
            r_mem_wr <= r_mem_wr;
         end
      end
   end

   assign f_gnt     = w_f_gnt;
   assign d_gnt     = w_d_gnt;
   assign f_done    = r_f_done;
   assign d_done    = r_d_done;
   assign rdata     = r_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_vz16_bus_arbiter.sv
// Self-checking bench for vz16_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_vz16_bus_arbiter;

   localparam int P_WS   = 1;
   localparam int P_FAIR = 4;
   localparam int P_TO   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req, d_req, d_we, mem_ready;
   logic [15:0] f_addr, d_addr, d_wdata, mem_rdata;

   logic        f_gnt, f_done, d_gnt, d_done, mem_rd, mem_wr, bus_err;
   logic [15:0] rdata, mem_addr, mem_wdata;

   logic        s3_f_gnt, s3_f_done, s3_d_gnt, s3_d_done, s3_mem_rd, s3_mem_wr, s3_bus_err;
   logic [15:0] s3_rdata, s3_mem_addr, s3_mem_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vz16_bus_arbiter #(.WAIT_STATES(P_WS), .FAIR_LIMIT(P_FAIR), .TIMEOUT_CYCLES(P_TO)) u_dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
   );

   vz16_bus_arbiter #(.WAIT_STATES(3), .FAIR_LIMIT(P_FAIR), .TIMEOUT_CYCLES(64)) u_dut_ws3 (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(s3_f_gnt), .f_done(s3_f_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(s3_d_gnt), .d_done(s3_d_done), .rdata(s3_rdata),
      .mem_addr(s3_mem_addr), .mem_wdata(s3_mem_wdata), .mem_rd(s3_mem_rd), .mem_wr(s3_mem_wr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(s3_bus_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      cyc();
      reset = 1'b0; f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== 2'b00) begin
         errors++; $display("FAIL reset_gnt: got %b expected 00", {f_gnt, d_gnt});
      end
      checks++;
      if ({mem_rd, mem_wr, f_done, d_done, bus_err} !== 5'b00000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_rd, mem_wr, f_done, d_done, bus_err});
      end
      checks++;
      if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin
         errors++; $display("FAIL reset_data: got %h expected 0", {rdata, mem_addr, mem_wdata});
      end
      cyc();
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt, mem_rd, mem_wr, f_done, d_done} !== 6'b000000) begin
         errors++; $display("FAIL reset_idle: got %b expected 000000", {f_gnt, d_gnt, mem_rd, mem_wr, f_done, d_done});
      end
   endtask

   task automatic test_fetch_read();
      cyc();
      f_req = 1'b1; f_addr = 16'h0100; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== 2'b10) begin
         errors++; $display("FAIL fetch_gnt: got %b expected 10", {f_gnt, d_gnt});
      end
      for (int c = 1; c <= 2; c++) begin
         cyc();
         if (c == 1) f_req = 1'b0;
         @(negedge clk);
         checks++;
         if ({mem_rd, mem_wr, f_done, mem_addr} !== {3'b100, 16'h0100}) begin
            errors++; $display("FAIL fetch_access c%0d: got rd=%b wr=%b done=%b addr=%h expected 1 0 0 0100",
                               c, mem_rd, mem_wr, f_done, mem_addr);
         end
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({f_done, d_done, mem_rd, rdata} !== {3'b100, 16'hBEEF}) begin
         errors++; $display("FAIL fetch_done: got done=%b rd=%b rdata=%h expected done=1 rd=0 rdata=beef",
                            f_done, mem_rd, rdata);
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({f_done, mem_rd} !== 2'b00) begin
         errors++; $display("FAIL fetch_after: got done=%b rd=%b expected 0 0", f_done, mem_rd);
      end
   endtask

   task automatic test_priority();
      cyc();
      f_req = 1'b1; f_addr = 16'h0300; d_req = 1'b1; d_we = 1'b1;
      d_addr = 16'h2000; d_wdata = 16'h1234; mem_rdata = 16'h5A5A; mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== 2'b01) begin
         errors++; $display("FAIL prio_gnt: got %b expected 01", {f_gnt, d_gnt});
      end
      for (int c = 1; c <= 2; c++) begin
         cyc();
         if (c == 1) begin d_req = 1'b0; d_we = 1'b0; end
         @(negedge clk);
         checks++;
         if ({mem_rd, mem_wr, f_gnt, mem_addr, mem_wdata} !== {3'b010, 16'h2000, 16'h1234}) begin
            errors++; $display("FAIL prio_write c%0d: got rd=%b wr=%b fgnt=%b addr=%h wdata=%h expected 0 1 0 2000 1234",
                               c, mem_rd, mem_wr, f_gnt, mem_addr, mem_wdata);
         end
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({d_done, f_done, f_gnt, rdata} !== {3'b100, 16'hBEEF}) begin
         errors++; $display("FAIL prio_done: got ddone=%b fdone=%b fgnt=%b rdata=%h expected 1 0 0 beef",
                            d_done, f_done, f_gnt, rdata);
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== 2'b10) begin
         errors++; $display("FAIL prio_f_next: got %b expected 10", {f_gnt, d_gnt});
      end
      cyc();
      f_req = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic test_fairness();
      logic [9:0] exp_f_seq;
      int t;
      exp_f_seq = 10'b1000010000;
      cyc();
      f_req = 1'b1; f_addr = 16'h0700; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2100; mem_ready = 1'b1;
      for (int g = 0; g < 10; g++) begin
         t = 0;
         @(negedge clk);
         while (!(f_gnt || d_gnt) && (t < 10)) begin
            @(negedge clk);
            t++;
         end
         checks++;
         if (t >= 10) begin
            errors++; $display("FAIL fair_wait g%0d: no grant within 10 cycles, expected one", g);
         end else if ({f_gnt, d_gnt} !== {exp_f_seq[g], ~exp_f_seq[g]}) begin
            errors++; $display("FAIL fair_seq g%0d: got f=%b d=%b expected f=%b d=%b",
                               g, f_gnt, d_gnt, exp_f_seq[g], ~exp_f_seq[g]);
         end
      end
      cyc();
      f_req = 1'b0; d_req = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic test_stretch();
      logic [9:0] ready_pat;
      ready_pat = 10'b1000001010;
      do_reset();
      f_req = 1'b1; f_addr = 16'h0400;
      @(negedge clk);
      checks++;
      if (s3_f_gnt !== 1'b1) begin
         errors++; $display("FAIL stretch_gnt: got %b expected 1", s3_f_gnt);
      end
      for (int k = 1; k <= 9; k++) begin
         cyc();
         f_req = 1'b0; mem_ready = ready_pat[k]; mem_rdata = 16'h4000 + 16'(k);
         @(negedge clk);
         checks++;
         if ({s3_mem_rd, s3_f_done, s3_mem_addr} !== {2'b10, 16'h0400}) begin
            errors++; $display("FAIL stretch_access k%0d: got rd=%b done=%b addr=%h expected 1 0 0400",
                               k, s3_mem_rd, s3_f_done, s3_mem_addr);
         end
      end
      cyc();
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({s3_f_done, s3_mem_rd, s3_rdata} !== {2'b10, 16'h4009}) begin
         errors++; $display("FAIL stretch_done: got done=%b rd=%b rdata=%h expected 1 0 4009",
                            s3_f_done, s3_mem_rd, s3_rdata);
      end
   endtask

   task automatic test_reset_mid();
      cyc();
      f_req = 1'b1; f_addr = 16'h0500; mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (f_gnt !== 1'b1) begin
         errors++; $display("FAIL rstmid_gnt: got %b expected 1", f_gnt);
      end
      cyc();
      f_req = 1'b0;
      #1;
      checks++;
      if (mem_rd !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: got mem_rd=%b expected 1", mem_rd);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_rd, mem_wr} !== 2'b00) begin
         errors++; $display("FAIL rstmid_drop: got rd=%b wr=%b expected 0 0", mem_rd, mem_wr);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({f_done, d_done, mem_rd} !== 3'b000) begin
            errors++; $display("FAIL rstmid_hold c%0d: got %b expected 000", c, {f_done, d_done, mem_rd});
         end
      end
      cyc();
      reset = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hC0DE;
      @(negedge clk);
      checks++;
      if ({f_done, d_done, mem_rd} !== 3'b000) begin
         errors++; $display("FAIL rstmid_release: got %b expected 000", {f_done, d_done, mem_rd});
      end
      cyc();
      f_req = 1'b1; f_addr = 16'h0510;
      @(negedge clk);
      checks++;
      if (f_gnt !== 1'b1) begin
         errors++; $display("FAIL rstmid_regnt: got %b expected 1", f_gnt);
      end
      cyc();
      f_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_addr} !== {1'b1, 16'h0510}) begin
         errors++; $display("FAIL rstmid_access: got rd=%b addr=%h expected 1 0510", mem_rd, mem_addr);
      end
      repeat (2) cyc();
      @(negedge clk);
      checks++;
      if ({f_done, rdata} !== {1'b1, 16'hC0DE}) begin
         errors++; $display("FAIL rstmid_done: got done=%b rdata=%h expected 1 c0de", f_done, rdata);
      end
   endtask

   task automatic test_timeout();
      cyc();
      f_req = 1'b1; f_addr = 16'h0600; mem_ready = 1'b0; mem_rdata = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (f_gnt !== 1'b1) begin
         errors++; $display("FAIL to_gnt: got %b expected 1", f_gnt);
      end
      for (int k = 1; k <= P_TO; k++) begin
         cyc();
         f_req = 1'b0;
         @(negedge clk);
         checks++;
         if ({mem_rd, f_done, bus_err} !== 3'b100) begin
            errors++; $display("FAIL to_access k%0d: got rd=%b done=%b err=%b expected 1 0 0", k, mem_rd, f_done, bus_err);
         end
      end
`ifdef VZ16_BUS_TIMEOUT_EN
      cyc();
      @(negedge clk);
      checks++;
      if ({f_done, bus_err, mem_rd, rdata} !== {3'b110, 16'h0000}) begin
         errors++; $display("FAIL to_abort: got done=%b err=%b rd=%b rdata=%h expected 1 1 0 0000",
                            f_done, bus_err, mem_rd, rdata);
      end
      cyc();
      @(negedge clk);
      checks++;
      if ({f_done, bus_err, mem_rd} !== 3'b000) begin
         errors++; $display("FAIL to_after: got %b expected 000", {f_done, bus_err, mem_rd});
      end
`else
      for (int k = P_TO + 1; k <= P_TO + 12; k++) begin
         cyc();
         @(negedge clk);
         checks++;
         if ({mem_rd, f_done, bus_err} !== 3'b100) begin
            errors++; $display("FAIL to_wait k%0d: got rd=%b done=%b err=%b expected 1 0 0", k, mem_rd, f_done, bus_err);
         end
      end
      do_reset();
`endif
   endtask

   task automatic test_random();
      int          m_k, m_fair;
      bit          m_resp, m_own_d, m_we, m_err;
      logic [15:0] m_addr, m_wdata, m_rdata;
      bit          e_fg, e_dg, e_rd, e_wr, e_fd, e_dd, e_err;
      m_k = 0; m_fair = 0; m_resp = 1'b0; m_own_d = 1'b0; m_we = 1'b0; m_err = 1'b0;
      m_addr = 16'h0000; m_wdata = 16'h0000; m_rdata = 16'h0000;
      e_fg = 1'b0; e_dg = 1'b0;
      do_reset();
      for (int cyc_n = 0; cyc_n < 1500 && errors < 50; cyc_n++) begin
         if (cyc_n != 0) cyc();
         if (e_fg) f_req = 1'b0;
         if (e_dg) d_req = 1'b0;
         if (!f_req && ($urandom_range(0, 2) == 0)) begin
            f_req = 1'b1; f_addr = 16'($urandom);
         end
         if (!d_req && ($urandom_range(0, 2) == 0)) begin
            d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         mem_rdata = 16'($urandom);
         @(negedge clk);
         e_fg = 1'b0; e_dg = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_fd = 1'b0; e_dd = 1'b0; e_err = 1'b0;
         if (m_resp) begin
            e_fd = !m_own_d; e_dd = m_own_d; e_err = m_err;
         end else if (m_k > 0) begin
            e_rd = !m_we; e_wr = m_we;
         end else begin
            e_fg = f_req && (!d_req || (m_fair == P_FAIR));
            e_dg = d_req && !e_fg;
         end
         checks++;
         if ({f_gnt, d_gnt} !== {e_fg, e_dg}) begin
            errors++; $display("FAIL rnd_gnt cyc%0d: got %b expected %b", cyc_n, {f_gnt, d_gnt}, {e_fg, e_dg});
         end
         checks++;
         if ({mem_rd, mem_wr} !== {e_rd, e_wr}) begin
            errors++; $display("FAIL rnd_strobe cyc%0d: got %b expected %b", cyc_n, {mem_rd, mem_wr}, {e_rd, e_wr});
         end
         checks++;
         if ({f_done, d_done, bus_err} !== {e_fd, e_dd, e_err}) begin
            errors++; $display("FAIL rnd_done cyc%0d: got %b expected %b", cyc_n, {f_done, d_done, bus_err}, {e_fd, e_dd, e_err});
         end
         checks++;
         if (rdata !== m_rdata) begin
            errors++; $display("FAIL rnd_rdata cyc%0d: got %h expected %h", cyc_n, rdata, m_rdata);
         end
         if (m_k > 0 && !m_resp) begin
            checks++;
            if (mem_addr !== m_addr || (m_we && (mem_wdata !== m_wdata))) begin
               errors++; $display("FAIL rnd_bus cyc%0d: got addr=%h wdata=%h expected addr=%h wdata=%h (write=%b)",
                                  cyc_n, mem_addr, mem_wdata, m_addr, m_wdata, m_we);
            end
         end
         if (m_resp) begin
            m_resp = 1'b0; m_k = 0;
         end else if (m_k > 0) begin
            if ((m_k >= P_WS + 1) && mem_ready) begin
               m_resp = 1'b1; m_err = 1'b0;
               if (!m_we) m_rdata = mem_rdata;
`ifdef VZ16_BUS_TIMEOUT_EN
            end else if (m_k == P_TO) begin
               m_resp = 1'b1; m_err = 1'b1; m_rdata = 16'h0000;
`endif
            end else begin
               m_k++;
            end
         end else if (e_fg || e_dg) begin
            m_own_d = e_dg;
            m_we    = e_dg && d_we;
            m_addr  = e_dg ? d_addr : f_addr;
            if (e_dg) m_wdata = d_wdata;
            if (e_fg) m_fair = 0;
            else if (f_req && (m_fair < P_FAIR)) m_fair++;
            m_k = 1;
         end
      end
   endtask

   initial begin
      reset = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      f_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000; mem_rdata = 16'h0000;
      test_reset();
      test_fetch_read();
      test_priority();
      test_fairness();
      test_stretch();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within 1000000 time units");
      $fatal(1);
   end

endmodule
